// File: rtl/wb_cache.sv
// Direct-mapped, write-back, write-allocate cache between a single-word CPU port
// and a word-granular backing memory; a single FSM sequences lookup, writeback and refill.
module wb_cache #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int INDEX_WIDTH    = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  output logic                  hit,
  output logic                  miss,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam int WORD_W = $clog2(WORDS_PER_LINE);
  localparam int LINES  = 2 ** INDEX_WIDTH;
  localparam int TAG_W  = ADDR_WIDTH - BYTE_W - WORD_W - INDEX_WIDTH;
  localparam int SLOT_W = INDEX_WIDTH + WORD_W;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, REFILL, DONE} state_t;

  state_t                  state;
  logic                    req_we;
  logic [TAG_W-1:0]        req_tag;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [WORD_W-1:0]       req_word;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [WORD_W-1:0]       cnt;
  logic [WORD_W-1:0]       cnt_next;
  logic                    hit_path;
  logic [LINES-1:0]        valid;
  logic [LINES-1:0]        dirty;

  logic [TAG_W-1:0]        tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]   data_mem [2**SLOT_W];

  logic [TAG_W-1:0]        line_tag;
  logic                    lookup_hit;
  logic                    wr_en;
  logic [SLOT_W-1:0]       wr_slot;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    tag_we;
  logic                    unused_addr_bits;

  // Byte-offset bits select nothing in a word-granular cache.
  assign unused_addr_bits = ^cpu_addr;

  assign line_tag   = tag_mem[req_index];
  assign lookup_hit = valid[req_index] && (line_tag == req_tag);
  assign cnt_next   = cnt + WORD_W'(1);

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [TAG_W-1:0]       tag,
                                                      input logic [INDEX_WIDTH-1:0] idx,
                                                      input logic [WORD_W-1:0]      word);
    word_addr = ADDR_WIDTH'({tag, idx, word}) << BYTE_W;
  endfunction

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    wr_en   = 1'b0;
    wr_slot = {req_index, req_word};
    wr_data = req_wdata;
    tag_we  = 1'b0;
    case (state)
      COMPARE: wr_en = lookup_hit && req_we;
      REFILL: begin
        if (mem_ack) begin
          wr_en   = 1'b1;
          wr_slot = {req_index, cnt};
          wr_data = mem_rdata;
          tag_we  = (cnt == LAST_WORD);
        end
      end
      DONE:    wr_en = !hit_path && req_we;
      default: ;
    endcase
    if (rst) begin
      wr_en  = 1'b0;
      tag_we = 1'b0;
    end
  end

  // NOTE: tag and data arrays are not reset; valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (wr_en)  data_mem[wr_slot]  <= wr_data;
    if (tag_we) tag_mem[req_index] <= req_tag;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      valid     <= '0;
      dirty     <= '0;
      hit_path  <= 1'b0;
      req_we    <= 1'b0;
      req_tag   <= '0;
      req_index <= '0;
      req_word  <= '0;
      req_wdata <= '0;
      cpu_ready <= 1'b0;
      hit       <= 1'b0;
      miss      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      cpu_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      hit       <= 1'b0;
      miss      <= 1'b0;
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_tag   <= cpu_addr[ADDR_WIDTH-1 -: TAG_W];
            req_index <= cpu_addr[BYTE_W+WORD_W +: INDEX_WIDTH];
            req_word  <= cpu_addr[BYTE_W +: WORD_W];
            req_wdata <= cpu_wdata;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (lookup_hit) begin
            hit      <= 1'b1;
            hit_path <= 1'b1;
            if (req_we) dirty[req_index] <= 1'b1;
            else        cpu_rdata <= data_mem[{req_index, req_word}];
            state    <= DONE;
          end else begin
            miss    <= 1'b1;
            mem_req <= 1'b1;
            cnt     <= '0;
            if (valid[req_index] && dirty[req_index]) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_addr(line_tag, req_index, {WORD_W{1'b0}});
              mem_wdata <= data_mem[{req_index, {WORD_W{1'b0}}}];
              state     <= WRITEBACK;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= word_addr(req_tag, req_index, {WORD_W{1'b0}});
              state    <= REFILL;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            if (cnt == LAST_WORD) begin
              // mem_req stays high straight into the refill burst.
              cnt      <= '0;
              mem_we   <= 1'b0;
              mem_addr <= word_addr(req_tag, req_index, {WORD_W{1'b0}});
              state    <= REFILL;
            end else begin
              cnt       <= cnt_next;
              mem_addr  <= word_addr(line_tag, req_index, cnt_next);
              mem_wdata <= data_mem[{req_index, cnt_next}];
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            if (cnt == LAST_WORD) begin
              cnt              <= '0;
              valid[req_index] <= 1'b1;
              dirty[req_index] <= 1'b0;
              mem_req          <= 1'b0;
              state            <= DONE;
            end else begin
              cnt      <= cnt_next;
              mem_addr <= word_addr(req_tag, req_index, cnt_next);
            end
          end
        end
        DONE: begin
          // A hit already performed its access in COMPARE; only the miss path completes it here.
          if (!hit_path) begin
            if (req_we) dirty[req_index] <= 1'b1;
            else        cpu_rdata <= data_mem[{req_index, req_word}];
          end
          hit_path  <= 1'b0;
          cpu_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cache.sv
// Directed bench for wb_cache: a word memory model with configurable ack spacing,
// pulse/traffic monitors, and hand-computed expectations per access.
module tb_wb_cache;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready, hit, miss;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;

  wb_cache dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .hit(hit), .miss(miss),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory model and traffic log
  logic [DW-1:0] mem_model [16384];
  logic [AW-1:0] log_addr  [$];
  logic          log_we    [$];
  logic [DW-1:0] log_wdata [$];
  int            gap = 0;
  int            unstable = 0;

  initial begin
    int            wait_left;
    bit            pending;
    logic [AW-1:0] p_addr;
    logic          p_we;
    logic [DW-1:0] p_wdata;
    wait_left = 0;
    pending   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req) begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;
        wait_left = gap;
        pending   = 1'b0;
      end else begin
        if (mem_ack) begin
          wait_left = gap;
          pending   = 1'b0;
        end
        if (pending && (mem_addr !== p_addr || mem_we !== p_we || (mem_we && mem_wdata !== p_wdata)))
          unstable++;
        p_addr  = mem_addr;
        p_we    = mem_we;
        p_wdata = mem_wdata;
        pending = 1'b1;
        if (wait_left == 0) begin
          mem_ack = 1'b1;
          log_addr.push_back(mem_addr);
          log_we.push_back(mem_we);
          log_wdata.push_back(mem_wdata);
          if (mem_we) begin
            mem_model[mem_addr[15:2]] = mem_wdata;
            mem_rdata = 32'h5A5A_5A5A;
          end else begin
            mem_rdata = mem_model[mem_addr[15:2]];
          end
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'h5A5A_5A5A;
          wait_left--;
        end
      end
    end
  end

  // Pulse and traffic monitors
  int hit_cnt = 0, miss_cnt = 0, ready_cnt = 0, memreq_cyc = 0, excl_bad = 0;
  always @(negedge clk) begin
    if (hit)       hit_cnt    <= hit_cnt + 1;
    if (miss)      miss_cnt   <= miss_cnt + 1;
    if (cpu_ready) ready_cnt  <= ready_cnt + 1;
    if (mem_req)   memreq_cyc <= memreq_cyc + 1;
    if (int'(hit) + int'(miss) + int'(cpu_ready) > 1) excl_bad <= excl_bad + 1;
  end

  // Results of the last access
  logic [DW-1:0] r_rdata;
  logic          r_ready_seen;
  int r_lat, r_hit, r_miss, r_ready, r_memreq, r_log0, r_nlog;

  task automatic run(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int h0, m0, rd0, mq0;
    @(negedge clk);
    h0 = hit_cnt; m0 = miss_cnt; rd0 = ready_cnt; mq0 = memreq_cyc;
    r_log0 = log_addr.size();
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = ~we; cpu_addr = ~addr; cpu_wdata = ~wdata;
    r_lat = 0;
    while (!cpu_ready && r_lat < 200) begin
      @(negedge clk);
      r_lat++;
    end
    r_ready_seen = cpu_ready;
    r_rdata      = cpu_rdata;
    @(negedge clk);
    r_hit    = hit_cnt - h0;
    r_miss   = miss_cnt - m0;
    r_ready  = ready_cnt - rd0;
    r_memreq = memreq_cyc - mq0;
    r_nlog   = log_addr.size() - r_log0;
  endtask

  task automatic expect_access(input string t, input int ehit, input int emiss, input int elat,
                               input int enlog);
    check({t, "_ready_seen"}, r_ready_seen, 1);
    check({t, "_hit"}, r_hit, ehit);
    check({t, "_miss"}, r_miss, emiss);
    check({t, "_ready_cnt"}, r_ready, 1);
    check({t, "_lat"}, r_lat, elat);
    check({t, "_nlog"}, r_nlog, enlog);
  endtask

  task automatic expect_log(input string t, input int k, input logic [AW-1:0] addr, input logic we,
                            input logic [DW-1:0] wdata);
    int i;
    i = r_log0 + k;
    if (i < log_addr.size()) begin
      check($sformatf("%s_addr%0d", t, k), log_addr[i], addr);
      check($sformatf("%s_we%0d", t, k), log_we[i], we);
      if (we) check($sformatf("%s_wdata%0d", t, k), log_wdata[i], wdata);
    end else begin
      check($sformatf("%s_log%0d_present", t, k), log_addr.size(), i + 1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [DW-1:0] A0 = 32'hA0A0_0000, A1 = 32'hA1A1_1111;
  localparam logic [DW-1:0] A2 = 32'hA2A2_2222, A3 = 32'hA3A3_3333;

  initial begin
    logic [DW-1:0] line_a [4];
    int rd0;
    int budget;
    line_a[0] = A0; line_a[1] = A1; line_a[2] = A2; line_a[3] = A3;
    for (int i = 0; i < 16384; i++) mem_model[i] = 32'hC000_0000 | i;
    for (int k = 0; k < 4; k++) mem_model[(16'h0120 >> 2) + k] = line_a[k];

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_hit_miss", {hit, miss}, 0);
    check("rst_mem_req_we", {mem_req, mem_we}, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    // Cold read miss, ack every cycle
    gap = 0;
    run(1'b0, 16'h0124, '0);
    expect_access("cold", 0, 1, 6, 4);
    check("cold_rdata", r_rdata, A1);
    for (int k = 0; k < 4; k++) expect_log("cold", k, 16'h0120 + 16'(4 * k), 1'b0, '0);

    // Read hit in the same line
    run(1'b0, 16'h0128, '0);
    expect_access("hit_rd", 1, 0, 2, 0);
    check("hit_rd_rdata", r_rdata, A2);
    check("hit_rd_memreq", r_memreq, 0);

    // Write hit then read back
    run(1'b1, 16'h0124, 32'hDEAD_BEEF);
    expect_access("hit_wr", 1, 0, 2, 0);
    check("hit_wr_memreq", r_memreq, 0);
    run(1'b0, 16'h0124, '0);
    expect_access("hit_rb", 1, 0, 2, 0);
    check("hit_rb_rdata", r_rdata, 32'hDEAD_BEEF);
    check("hit_rb_memreq", r_memreq, 0);

    // Conflict miss on a dirty line: writeback then refill
    run(1'b0, 16'h1124, '0);
    expect_access("evict", 0, 1, 10, 8);
    check("evict_rdata", r_rdata, 32'hC000_0449);
    expect_log("evict", 0, 16'h0120, 1'b1, A0);
    expect_log("evict", 1, 16'h0124, 1'b1, 32'hDEAD_BEEF);
    expect_log("evict", 2, 16'h0128, 1'b1, A2);
    expect_log("evict", 3, 16'h012C, 1'b1, A3);
    for (int k = 0; k < 4; k++) expect_log("evict", 4 + k, 16'h1120 + 16'(4 * k), 1'b0, '0);

    // Write miss with ack every 4th cycle
    gap = 3;
    run(1'b1, 16'h0230, 32'h1234_5678);
    expect_access("wmiss", 0, 1, 18, 4);
    check("wmiss_memreq_cycles", r_memreq, 16);
    for (int k = 0; k < 4; k++) expect_log("wmiss", k, 16'h0230 + 16'(4 * k), 1'b0, '0);
    run(1'b0, 16'h0230, '0);
    expect_access("wmiss_rb", 1, 0, 2, 0);
    check("wmiss_rb_rdata", r_rdata, 32'h1234_5678);
    check("stable_during_waits", unstable, 0);

    // Reset in the middle of a refill burst
    @(negedge clk);
    rd0 = ready_cnt;
    r_log0 = log_addr.size();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0340;
    @(negedge clk);
    cpu_req = 1'b0;
    budget = 0;
    while (log_addr.size() < r_log0 + 2 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    check("rstmid_two_acks", log_addr.size(), r_log0 + 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_mem_req", mem_req, 0);
    check("rstmid_cpu_ready", cpu_ready, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rstmid_no_ready", ready_cnt - rd0, 0);
    check("rstmid_mem_idle", mem_req, 0);
    run(1'b0, 16'h0340, '0);
    expect_access("rstmid_reread", 0, 1, 18, 4);
    check("rstmid_reread_rdata", r_rdata, 32'hC000_00D0);
    for (int k = 0; k < 4; k++) expect_log("rstmid_reread", k, 16'h0340 + 16'(4 * k), 1'b0, '0);

    check("pulses_exclusive", excl_bad, 0);
    check("stable_final", unstable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
